scan_multiplexer: RTL and testbench

Parametrised time-division channel scanner: an internal one-hot ring counter steps through `CHANNELS` input words of `WIDTH` bits, dwelling `DWELL` clocks on each, and presents the selected word on a registered output. A per-channel mask skips disconnected channels. It sits between the sensor/actuator data buses and the shared serial display or logging path, and replaces the external ring counter plus fixed 4-input, 1-bit selector.

---
 rtl/scan_multiplexer_pkg.sv | 16 +
 rtl/scan_multiplexer_next_channel_finder.sv | 44 ++++
 rtl/scan_multiplexer.sv | 82 ++++++++
 tb/tb_scan_multiplexer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/scan_multiplexer_pkg.sv
// Shared scan definitions: counter-width and bus-slice macros plus helpers
// used by the channel scanner and its next-channel finder.
`ifndef SCAN_DEFS_VH
`define SCAN_DEFS_VH
`define CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`define CH_SLICE(bus, i, w) bus[(i)*(w) +: (w)]
`endif

package scan_multiplexer_pkg;

    // Folds an index in [0, 2*c) back into [0, c).
    function automatic int wrap_index(input int n, input int c);
        return (n >= c) ? n - c : n;
    endfunction

endpackage

// File: rtl/scan_multiplexer_next_channel_finder.sv
// Next masked-in channel after the current one-hot ring position,
// found by rotating the mask past the current index and priority-encoding.
module next_channel_finder
    import scan_multiplexer_pkg::*;
#(
    parameter int CHANNELS = 4
) (
    input  logic [CHANNELS-1:0] ring,
    input  logic [CHANNELS-1:0] channel_mask,
    output logic [CHANNELS-1:0] next_ring,
    output logic                wrapped
);

    logic [2*CHANNELS-1:0] doubled;
    logic [CHANNELS-1:0]   rotated;
    int                    cur;
    int                    step;
    int                    nxt;

    assign doubled = {channel_mask, channel_mask};

    always_comb begin
        cur = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ring[i]) cur = i;
        end
        rotated = CHANNELS'(doubled >> (cur + 1));
        step = 0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (rotated[k]) step = k;
        end
        nxt = wrap_index(cur + 1 + step, CHANNELS);
        next_ring = ring;
        wrapped   = 1'b0;
        // An empty mask leaves the selection where it is.
        if (|channel_mask) begin
            for (int i = 0; i < CHANNELS; i++) begin
                next_ring[i] = (i == nxt);
            end
            wrapped = (nxt <= cur);
        end
    end

endmodule

// File: rtl/scan_multiplexer.sv
// Time-division channel scanner: one-hot ring with per-channel dwell,
// mask-driven skipping and a registered, frame-tagged output word.
module scan_multiplexer
    import scan_multiplexer_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 1,
    parameter int DWELL    = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [CHANNELS-1:0]       channel_mask,
    input  logic [CHANNELS*WIDTH-1:0] data,
    output logic [WIDTH-1:0]          out,
    output logic [CHANNELS-1:0]       out_sel,
    output logic                      out_valid,
    output logic                      frame_start
);

    localparam int DW = `CLOG2(DWELL);

    logic [CHANNELS-1:0] ring;
    logic [DW-1:0]       dwell_cnt;
    logic                wrap_flag;

    logic [CHANNELS-1:0] next_ring;
    logic                wrapped;
    logic [WIDTH-1:0]    sel_word;
    logic                cur_valid;
    logic                any_mask;
    logic                at_end;
    logic                advance;

    next_channel_finder #(
        .CHANNELS(CHANNELS)
    ) u_finder (
        .ring(ring),
        .channel_mask(channel_mask),
        .next_ring(next_ring),
        .wrapped(wrapped)
    );

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sel_word |= {WIDTH{ring[i]}} & `CH_SLICE(data, i, WIDTH);
        end
    end

    assign cur_valid = |(ring & channel_mask);
    assign any_mask  = |channel_mask;
    assign at_end    = (dwell_cnt == DW'(DWELL - 1));
    // A masked-out current channel is left at once, whatever the dwell.
    assign advance   = enable & any_mask & (at_end | ~cur_valid);

    always_ff @(posedge clock) begin
        if (reset) begin
            ring        <= CHANNELS'(1);
            dwell_cnt   <= '0;
            wrap_flag   <= 1'b1;
            out         <= '0;
            out_sel     <= '0;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            out         <= sel_word;
            out_sel     <= ring;
            out_valid   <= cur_valid;
            frame_start <= wrap_flag & cur_valid;
            if (wrap_flag & cur_valid) wrap_flag <= 1'b0;
            if (advance) begin
                dwell_cnt <= '0;
                ring      <= next_ring;
                if (wrapped) wrap_flag <= 1'b1;
            end else if (enable & any_mask) begin
                dwell_cnt <= dwell_cnt + DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_scan_multiplexer.sv
// Directed bench for scan_multiplexer: two instances (DWELL=1, DWELL=3)
// sharing clock, reset, enable and data, with independent masks.
module tb_scan_multiplexer;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [3:0]  m1;
    logic [3:0]  m3;
    logic [31:0] data;

    logic [7:0] o1, o3;
    logic [3:0] s1, s3;
    logic       v1, v3, f1, f3;

    int n_assert = 0;
    int n_fail   = 0;

    scan_multiplexer #(.CHANNELS(4), .WIDTH(8), .DWELL(1)) u1 (
        .clock(clk), .reset(reset), .enable(enable),
        .channel_mask(m1), .data(data),
        .out(o1), .out_sel(s1), .out_valid(v1), .frame_start(f1)
    );

    scan_multiplexer #(.CHANNELS(4), .WIDTH(8), .DWELL(3)) u3 (
        .clock(clk), .reset(reset), .enable(enable),
        .channel_mask(m3), .data(data),
        .out(o3), .out_sel(s3), .out_valid(v3), .frame_start(f3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic [7:0] o,
                        input logic [3:0] s, input logic v,
                        input logic f);
        chk({tag, ".u1.out"}, 32'(o1), 32'(o));
        chk({tag, ".u1.sel"}, 32'(s1), 32'(s));
        chk({tag, ".u1.valid"}, 32'(v1), 32'(v));
        chk({tag, ".u1.fs"}, 32'(f1), 32'(f));
    endtask

    task automatic chk3(input string tag, input logic [3:0] s,
                        input logic v, input logic f);
        chk({tag, ".u3.sel"}, 32'(s3), 32'(s));
        chk({tag, ".u3.valid"}, 32'(v3), 32'(v));
        chk({tag, ".u3.fs"}, 32'(f3), 32'(f));
    endtask

    logic [7:0] e1_out [8];
    logic [3:0] e1_sel [8];
    logic       e1_fs  [8];
    logic [3:0] e3_sel [8];
    logic       e3_v   [8];
    logic       e3_fs  [8];

    initial begin
        e1_out = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hA0, 8'hB1, 8'hC2, 8'hD3};
        e1_sel = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
        e1_fs  = '{1, 0, 0, 0, 1, 0, 0, 0};
        e3_sel = '{4'h1, 4'h2, 4'h2, 4'h2, 4'h8, 4'h8, 4'h8, 4'h2};
        e3_v   = '{0, 1, 1, 1, 1, 1, 1, 1};
        e3_fs  = '{0, 1, 0, 0, 0, 0, 0, 1};

        reset  = 1'b1;
        enable = 1'b1;
        m1     = 4'b1111;
        m3     = 4'b1010;
        data   = 32'hD3C2B1A0;
        step();
        step();
        chk1("reset", 8'h00, 4'h0, 1'b0, 1'b0);
        chk3("reset", 4'h0, 1'b0, 1'b0);
        chk("reset.u3.out", 32'(o3), 32'h0);
        reset = 1'b0;

        // E1..E8: full-mask rotation and the 1010 mask with DWELL=3
        for (int i = 0; i < 8; i++) begin
            step();
            chk1($sformatf("scan%0d", i), e1_out[i], e1_sel[i],
                 1'b1, e1_fs[i]);
            chk3($sformatf("scan%0d", i), e3_sel[i], e3_v[i], e3_fs[i]);
        end

        // current channel 1 masked out one clock into its dwell
        m3 = 4'b1100;
        step();
        chk3("drop", 4'h2, 1'b0, 1'b0);
        chk("drop.u3.out", 32'(o3), 32'hB1);
        step();
        chk3("jump0", 4'h4, 1'b1, 1'b0);
        chk("jump0.u3.out", 32'(o3), 32'hC2);
        step();
        chk3("jump1", 4'h4, 1'b1, 1'b0);
        step();
        chk3("jump2", 4'h4, 1'b1, 1'b0);
        step();
        chk3("jump3", 4'h8, 1'b1, 1'b0);

        // freeze for 5 cycles while channel 3 data changes
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            data[31:24] = 8'h10 + 8'(k);
            step();
            chk3($sformatf("hold%0d", k), 4'h8, 1'b1, 1'b0);
            chk($sformatf("hold%0d.u3.out", k), 32'(o3),
                32'h10 + 32'(k));
            chk1($sformatf("hold%0d", k), 8'hB1, 4'h2, 1'b1, 1'b0);
        end
        enable = 1'b1;
        data   = 32'hD3C2B1A0;
        step();
        chk3("resume0", 4'h8, 1'b1, 1'b0);
        chk1("resume0", 8'hB1, 4'h2, 1'b1, 1'b0);
        step();
        chk3("resume1", 4'h8, 1'b1, 1'b0);
        chk1("resume1", 8'hC2, 4'h4, 1'b1, 1'b0);
        step();
        chk3("resume2", 4'h4, 1'b1, 1'b1);
        chk1("resume2", 8'hD3, 4'h8, 1'b1, 1'b0);

        // empty mask on u1, then a single channel
        m1 = 4'b0000;
        step();
        chk1("empty0", 8'hA0, 4'h1, 1'b0, 1'b0);
        step();
        chk1("empty1", 8'hA0, 4'h1, 1'b0, 1'b0);
        m1 = 4'b0100;
        step();
        chk1("single0", 8'hA0, 4'h1, 1'b0, 1'b0);
        step();
        chk1("single1", 8'hC2, 4'h4, 1'b1, 1'b1);
        step();
        chk1("single2", 8'hC2, 4'h4, 1'b1, 1'b1);
        step();
        chk1("single3", 8'hC2, 4'h4, 1'b1, 1'b1);
        chk3("single3", 4'h4, 1'b1, 1'b1);

        // bring u3 to channel 3, then reset mid-scan
        step();
        step();
        step();
        chk3("pre_rst", 4'h8, 1'b1, 1'b0);
        reset = 1'b1;
        m3    = 4'b1111;
        step();
        chk3("mid_rst", 4'h0, 1'b0, 1'b0);
        chk("mid_rst.u3.out", 32'(o3), 32'h0);
        chk1("mid_rst", 8'h00, 4'h0, 1'b0, 1'b0);
        reset = 1'b0;
        step();
        chk3("post_rst0", 4'h1, 1'b1, 1'b1);
        chk("post_rst0.u3.out", 32'(o3), 32'hA0);
        chk1("post_rst0", 8'hA0, 4'h1, 1'b0, 1'b0);
        step();
        chk3("post_rst1", 4'h1, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
